// File: rtl/da_wav_ctrl.sv
// DAC waveform controller: divides sys_clk into DA_clk, runs a phase accumulator and
// emits square/saw/triangle/DC codes. Define DA_CLK_GATE_EN to stop DA_clk while idle.
module da_wav_ctrl #(
  parameter int unsigned DA_DIV    = 5,
  parameter int unsigned PHASE_W   = 32,
  parameter logic [7:0]  IDLE_CODE = 8'h80
) (
  input  logic               sys_clk,
  input  logic               rst,
  input  logic               run,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [1:0]         cfg_wave,
  input  logic [PHASE_W-1:0] cfg_step,
  input  logic [7:0]         cfg_hi,
  input  logic [7:0]         cfg_lo,
  output logic               DA_clk,
  output logic [7:0]         DA_digits,
  output logic               busy,
  output logic               period_tick
);

  localparam logic [7:0] DIV_LAST = 8'(DA_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_ARM} state_t;

  typedef struct packed {
    logic [1:0]         wave;
    logic [PHASE_W-1:0] step;
    logic [7:0]         hi;
    logic [7:0]         lo;
  } cfg_t;

  localparam cfg_t CFG_RST = '{wave: 2'd0, step: '0, hi: 8'hFF, lo: 8'h00};

  state_t             state;
  cfg_t               act_cfg;
  cfg_t               pend_cfg;
  cfg_t               in_cfg;
  cfg_t               use_cfg;
  logic               pend_valid;
  logic [7:0]         div_cnt;
  logic [PHASE_W-1:0] phase;
  logic [PHASE_W-1:0] phase_next;
  logic               wrap;
  logic               sample;
  logic               hs;
  logic               div_hold;
  logic [7:0]         code;

  function automatic logic [7:0] wave_code(input cfg_t c, input logic [7:0] p);
    logic [7:0]  span;
    logic [7:0]  q2;
    logic [15:0] prod;
    span = c.hi - c.lo;
    q2   = p[7] ? {~p[6:0], 1'b0} : {p[6:0], 1'b0};
    prod = '0;
    wave_code = c.hi;
    case (c.wave)
      2'd0: wave_code = p[7] ? c.lo : c.hi;
      2'd1: begin
        prod      = {8'd0, span} * {8'd0, p};
        wave_code = c.lo + prod[15:8];
      end
      2'd2: begin
        prod      = {8'd0, span} * {8'd0, q2};
        wave_code = c.lo + prod[15:8];
      end
      default: wave_code = c.hi;
    endcase
  endfunction

  // NOTE: every field is assigned on every pass, so no latch can be inferred.
  always_comb begin
    in_cfg.wave = cfg_wave;
    in_cfg.step = cfg_step;
    in_cfg.hi   = (cfg_hi < cfg_lo) ? cfg_lo : cfg_hi;
    in_cfg.lo   = (cfg_hi < cfg_lo) ? cfg_hi : cfg_lo;
  end

  assign cfg_ready = (state == S_IDLE) || ((state == S_RUN) && !pend_valid);
  assign busy      = (state != S_IDLE);
  assign hs        = cfg_valid && cfg_ready;
  // An idle handshake coinciding with the start event must already drive the first sample.
  assign use_cfg   = ((state == S_IDLE) && hs) ? in_cfg : act_cfg;
  assign {wrap, phase_next} = {1'b0, phase} + {1'b0, use_cfg.step};
  assign sample    = DA_clk && (div_cnt == DIV_LAST);
  assign code      = wave_code(use_cfg, phase[PHASE_W-1 -: 8]);

`ifdef DA_CLK_GATE_EN
  assign div_hold = (state == S_IDLE) && !run;
`else
  assign div_hold = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge sys_clk) begin
    if (rst || div_hold) begin
      div_cnt <= '0;
      DA_clk  <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
      DA_clk  <= ~DA_clk;
    end else begin
      div_cnt <= div_cnt + 8'd1;
    end
  end

  // Phase is kept at 0 throughout IDLE, so the start event always samples phase 0.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state       <= S_IDLE;
      phase       <= '0;
      DA_digits   <= IDLE_CODE;
      period_tick <= 1'b0;
      act_cfg     <= CFG_RST;
      pend_cfg    <= CFG_RST;
      pend_valid  <= 1'b0;
    end else begin
      period_tick <= 1'b0;
      case (state)
        S_IDLE: begin
          if (hs) act_cfg <= in_cfg;
          if (sample && run) begin
            state     <= S_RUN;
            phase     <= phase_next;
            DA_digits <= code;
          end
        end
        S_RUN, S_ARM: begin
          if (hs) begin
            pend_cfg   <= in_cfg;
            pend_valid <= 1'b1;
            state      <= S_ARM;
          end
          if (sample) begin
            period_tick <= wrap;
            if (!run && (wrap || (act_cfg.step == '0))) begin
              state      <= S_IDLE;
              phase      <= '0;
              DA_digits  <= IDLE_CODE;
              pend_valid <= 1'b0;
              if (hs)              act_cfg <= in_cfg;
              else if (pend_valid) act_cfg <= pend_cfg;
            end else if (wrap && pend_valid) begin
              act_cfg    <= pend_cfg;
              pend_valid <= 1'b0;
              state      <= S_RUN;
              phase      <= '0;
              DA_digits  <= code;
            end else begin
              phase     <= phase_next;
              DA_digits <= code;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_da_wav_ctrl.sv
// Directed bench for da_wav_ctrl (DA_DIV=5, PHASE_W=32); expected codes are hand-computed.
module tb_da_wav_ctrl;

  logic        sys_clk = 1'b0;
  logic        rst;
  logic        run;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  cfg_wave;
  logic [31:0] cfg_step;
  logic [7:0]  cfg_hi;
  logic [7:0]  cfg_lo;
  logic        DA_clk;
  logic [7:0]  DA_digits;
  logic        busy;
  logic        period_tick;

  int   vectors     = 0;
  int   miscompares = 0;
  logic ok;

  // Triangle, H=FF L=00, p stepping by 16 from 0 to 240.
  localparam logic [7:0] TRI_TAB [16] = '{8'h00, 8'h1F, 8'h3F, 8'h5F, 8'h7F, 8'h9F, 8'hBF, 8'hDF,
                                          8'hFD, 8'hDD, 8'hBD, 8'h9D, 8'h7D, 8'h5D, 8'h3D, 8'h1D};

  always #5 sys_clk = ~sys_clk;

  da_wav_ctrl #(.DA_DIV(5), .PHASE_W(32), .IDLE_CODE(8'h80)) dut (
    .sys_clk(sys_clk), .rst(rst), .run(run), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_wave(cfg_wave), .cfg_step(cfg_step), .cfg_hi(cfg_hi), .cfg_lo(cfg_lo),
    .DA_clk(DA_clk), .DA_digits(DA_digits), .busy(busy), .period_tick(period_tick)
  );

  // Advance to the negedge just after the next DA_clk falling edge.
  task automatic next_sample();
    logic p;
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      p = DA_clk;
      @(negedge sys_clk);
      if (p && !DA_clk) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      vectors++; miscompares++;
      $display("FAIL sample_timeout: no DA_clk fall within 64 cycles");
    end
  endtask

  task automatic send_cfg(input logic [1:0] w, input logic [31:0] s,
                          input logic [7:0] h, input logic [7:0] l);
    bit got = 1'b0;
    cfg_wave = w; cfg_step = s; cfg_hi = h; cfg_lo = l; cfg_valid = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (cfg_ready) begin
        got = 1'b1;
        break;
      end
      @(negedge sys_clk);
    end
    if (!got) begin
      vectors++; miscompares++;
      $display("FAIL cfg_timeout: cfg_ready stayed 0");
    end
    @(negedge sys_clk);
    cfg_valid = 1'b0;
  endtask

  task automatic stop_run();
    bit idle = 1'b0;
    run = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (!busy) begin
        idle = 1'b1;
        break;
      end
      @(negedge sys_clk);
    end
    if (!idle) begin
      vectors++; miscompares++;
      $display("FAIL stop_timeout: busy stayed 1");
    end
  endtask

  task automatic test_reset();
    logic p;
    int   n;
    rst = 1'b1; run = 1'b0; cfg_valid = 1'b0;
    cfg_wave = '0; cfg_step = '0; cfg_hi = '0; cfg_lo = '0;
    repeat (3) @(negedge sys_clk);
    vectors++; if (DA_digits !== 8'h80) begin miscompares++; $display("FAIL reset_digits got %02h expected 80", DA_digits); end
    vectors++; if (DA_clk !== 1'b0) begin miscompares++; $display("FAIL reset_da_clk got %b expected 0", DA_clk); end
    vectors++; if (cfg_ready !== 1'b1) begin miscompares++; $display("FAIL reset_cfg_ready got %b expected 1", cfg_ready); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b expected 0", busy); end
    vectors++; if (period_tick !== 1'b0) begin miscompares++; $display("FAIL reset_tick got %b expected 0", period_tick); end
    rst = 1'b0;
`ifndef DA_CLK_GATE_EN
    for (int i = 0; i < 40; i++) begin
      p = DA_clk;
      @(negedge sys_clk);
      if (!p && DA_clk) break;
    end
    n = 0;
    for (int i = 0; i < 40; i++) begin
      p = DA_clk;
      @(negedge sys_clk);
      n++;
      if (!p && DA_clk) break;
    end
    vectors++; if (n != 10) begin miscompares++; $display("FAIL da_clk_period got %0d expected 10", n); end
`else
    n = 0;
    repeat (30) begin
      @(negedge sys_clk);
      if (DA_clk !== 1'b0) n++;
    end
    vectors++; if (n != 0) begin miscompares++; $display("FAIL idle_gate got %0d high cycles expected 0", n); end
`endif
  endtask

  task automatic test_square();
    logic [7:0] exp;
    int n;
    send_cfg(2'd0, 32'h1000_0000, 8'hFF, 8'h8F);
    run = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp = (i < 8) ? 8'hFF : 8'h8F;
      next_sample();
      vectors++; if (DA_digits !== exp) begin miscompares++; $display("FAIL square_code[%0d] got %02h expected %02h", i, DA_digits, exp); end
      vectors++; if (period_tick !== (i == 15)) begin miscompares++; $display("FAIL square_tick[%0d] got %b expected %b", i, period_tick, (i == 15)); end
      if (i == 0) begin
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL square_busy got %b expected 1", busy); end
      end
    end
    n = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge sys_clk);
      n++;
      if (period_tick) break;
    end
    vectors++; if (n != 160) begin miscompares++; $display("FAIL tick_interval got %0d expected 160", n); end
  endtask

  task automatic test_mid_cfg();
    logic [7:0] exp;
    for (int i = 0; i < 3; i++) begin
      next_sample();
      vectors++; if (DA_digits !== 8'hFF) begin miscompares++; $display("FAIL mid_pre[%0d] got %02h expected FF", i, DA_digits); end
    end
    send_cfg(2'd3, 32'h1000_0000, 8'h40, 8'h00);
    vectors++; if (cfg_ready !== 1'b0) begin miscompares++; $display("FAIL mid_ready_low got %b expected 0", cfg_ready); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL mid_busy got %b expected 1", busy); end
    for (int k = 3; k < 16; k++) begin
      exp = (k < 8) ? 8'hFF : 8'h8F;
      next_sample();
      vectors++; if (DA_digits !== exp) begin miscompares++; $display("FAIL mid_old[%0d] got %02h expected %02h", k, DA_digits, exp); end
      vectors++; if (period_tick !== (k == 15)) begin miscompares++; $display("FAIL mid_tick[%0d] got %b expected %b", k, period_tick, (k == 15)); end
    end
    next_sample();
    vectors++; if (DA_digits !== 8'h40) begin miscompares++; $display("FAIL mid_new got %02h expected 40", DA_digits); end
    vectors++; if (cfg_ready !== 1'b1) begin miscompares++; $display("FAIL mid_ready_back got %b expected 1", cfg_ready); end
  endtask

  task automatic test_stop();
    int n;
    for (int k = 1; k < 3; k++) begin
      next_sample();
      vectors++; if (DA_digits !== 8'h40) begin miscompares++; $display("FAIL stop_pre[%0d] got %02h expected 40", k, DA_digits); end
    end
    run = 1'b0;
    for (int k = 3; k < 15; k++) begin
      next_sample();
      vectors++; if (DA_digits !== 8'h40) begin miscompares++; $display("FAIL stop_hold[%0d] got %02h expected 40", k, DA_digits); end
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL stop_busy[%0d] got %b expected 1", k, busy); end
    end
    next_sample();
    vectors++; if (DA_digits !== 8'h80) begin miscompares++; $display("FAIL stop_idle_code got %02h expected 80", DA_digits); end
    vectors++; if (period_tick !== 1'b1) begin miscompares++; $display("FAIL stop_tick got %b expected 1", period_tick); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL stop_busy_end got %b expected 0", busy); end
`ifndef DA_CLK_GATE_EN
    next_sample();
    vectors++; if (DA_digits !== 8'h80) begin miscompares++; $display("FAIL stop_stays_idle got %02h expected 80", DA_digits); end
`else
    n = 0;
    repeat (30) begin
      @(negedge sys_clk);
      if (DA_clk !== 1'b0) n++;
    end
    vectors++; if (n != 0) begin miscompares++; $display("FAIL stop_gate got %0d high cycles expected 0", n); end
`endif
  endtask

  task automatic test_swap();
    logic [7:0] exp;
    send_cfg(2'd0, 32'h1000_0000, 8'h10, 8'hF0);
    run = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp = (i < 8) ? 8'hF0 : 8'h10;
      next_sample();
      vectors++; if (DA_digits !== exp) begin miscompares++; $display("FAIL swap_code[%0d] got %02h expected %02h", i, DA_digits, exp); end
    end
    stop_run();
  endtask

  // Config handshake and run start land on the same sample edge while idle.
  task automatic test_back_to_back();
    bit started = 1'b0;
`ifndef DA_CLK_GATE_EN
    next_sample();
    repeat (9) @(negedge sys_clk);
`endif
    cfg_wave = 2'd2; cfg_step = 32'h1000_0000; cfg_hi = 8'hFF; cfg_lo = 8'h00;
    cfg_valid = 1'b1; run = 1'b1;
    @(negedge sys_clk);
    cfg_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (busy) begin
        started = 1'b1;
        break;
      end
      @(negedge sys_clk);
    end
    vectors++; if (!started) begin miscompares++; $display("FAIL b2b_start got busy=%b expected 1", busy); end
    vectors++; if (DA_digits !== TRI_TAB[0]) begin miscompares++; $display("FAIL tri_code[0] got %02h expected %02h", DA_digits, TRI_TAB[0]); end
    for (int i = 1; i < 16; i++) begin
      next_sample();
      vectors++; if (DA_digits !== TRI_TAB[i]) begin miscompares++; $display("FAIL tri_code[%0d] got %02h expected %02h", i, DA_digits, TRI_TAB[i]); end
      vectors++; if (period_tick !== (i == 15)) begin miscompares++; $display("FAIL tri_tick[%0d] got %b expected %b", i, period_tick, (i == 15)); end
    end
    stop_run();
  endtask

  task automatic test_sawtooth();
    logic [7:0] exp;
    send_cfg(2'd1, 32'h0100_0000, 8'h80, 8'h00);
    run = 1'b1;
    for (int i = 0; i < 256; i++) begin
      exp = 8'(i >> 1);
      next_sample();
      vectors++; if (DA_digits !== exp) begin miscompares++; $display("FAIL saw_code[%0d] got %02h expected %02h", i, DA_digits, exp); end
      vectors++; if (period_tick !== (i == 255)) begin miscompares++; $display("FAIL saw_tick[%0d] got %b expected %b", i, period_tick, (i == 255)); end
    end
  endtask

  // Reset while running must return to idle on the very next edge.
  task automatic test_reset_abort();
    repeat (5) next_sample();
    rst = 1'b1;
    @(negedge sys_clk);
    vectors++; if (DA_digits !== 8'h80) begin miscompares++; $display("FAIL abort_digits got %02h expected 80", DA_digits); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy got %b expected 0", busy); end
    vectors++; if (cfg_ready !== 1'b1) begin miscompares++; $display("FAIL abort_ready got %b expected 1", cfg_ready); end
    vectors++; if (DA_clk !== 1'b0) begin miscompares++; $display("FAIL abort_da_clk got %b expected 0", DA_clk); end
    rst = 1'b0; run = 1'b0;
  endtask

  initial begin
    test_reset();
    test_square();
    test_mid_cfg();
    test_stop();
    test_swap();
    test_back_to_back();
    test_sawtooth();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
